// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and configuration checks for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // WIDTH must split into whole chunks of at least one bit.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of the chunked adder; master issues operations, slave computes.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/seq_chunk_adder_full_adder_chain.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into the top bit.
module full_adder_chain #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c_s;

    // Ripple carry through each bit position.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = x[i] ^ y[i] ^ c_s[i];
            c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB chunk first.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_chunk_adder_if.slave   bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   x_s, y_s, s_s;
    logic               co_s, cmsb_s;

    assign x_s = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    assign y_s = b_q[int'(cnt_q) * CHUNK +: CHUNK];

    full_adder_chain #(.CHUNK(CHUNK)) u_chain (
        .x        (x_s),
        .y        (y_s),
        .ci       (carry_q),
        .s        (s_s),
        .co       (co_s),
        .c_msb_in (cmsb_s)
    );

    // Next-state, operand capture, per-chunk accumulation and completion flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1; a borrow-in removes that +1.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                psum_d[int'(cnt_q) * CHUNK +: CHUNK] = s_s;
                carry_d = co_s;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = psum_d;
                    cout_d  = co_s;
                    ovf_d   = co_s ^ cmsb_s;
                    zero_d  = (psum_d == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and randomized checks of seq_chunk_adder at CHUNK = 1, 4 and 16 (WIDTH 16).
module tb_seq_chunk_adder;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) if1  ();
    seq_chunk_adder_if #(.WIDTH(16)) if4  ();
    seq_chunk_adder_if #(.WIDTH(16)) if16 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    logic        done_a [3];
    logic        busy_a [3];
    logic [15:0] sum_a  [3];
    logic        cout_a [3];
    logic        ovf_a  [3];
    logic        zero_a [3];

    assign done_a[0] = if1.done;  assign done_a[1] = if4.done;  assign done_a[2] = if16.done;
    assign busy_a[0] = if1.busy;  assign busy_a[1] = if4.busy;  assign busy_a[2] = if16.busy;
    assign sum_a[0]  = if1.sum;   assign sum_a[1]  = if4.sum;   assign sum_a[2]  = if16.sum;
    assign cout_a[0] = if1.cout;  assign cout_a[1] = if4.cout;  assign cout_a[2] = if16.cout;
    assign ovf_a[0]  = if1.ovf;   assign ovf_a[1]  = if4.ovf;   assign ovf_a[2]  = if16.ovf;
    assign zero_a[0] = if1.zero;  assign zero_a[1] = if4.zero;  assign zero_a[2] = if16.zero;

    function automatic int nchunk_of(input int i);
        case (i)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int chunk_of(input int i);
        return 16 / nchunk_of(i);
    endfunction

    function automatic vec_t ref_model(input logic sub, input logic [15:0] a,
                                       input logic [15:0] b, input logic cin);
        vec_t        v;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 17'(cin ^ sub);
        v.sub  = sub;
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = full[15:0];
        v.cout = full[16];
        v.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        v.zero = (full[15:0] == 16'h0000);
        return v;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s chunk=%0d: got %0h, expected %0h", name, chunk_of(i), got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sub, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        if1.start  = st;  if1.sub  = sub; if1.a  = a; if1.b  = b; if1.cin  = cin;
        if4.start  = st;  if4.sub  = sub; if4.a  = a; if4.b  = b; if4.cin  = cin;
        if16.start = st;  if16.sub = sub; if16.a = a; if16.b = b; if16.cin = cin;
    endtask

    // One operation on all three instances; checks result, latency, single done pulse and busy span.
    task automatic run_op(input vec_t v, input string tag);
        int lat [3];
        int dcnt[3];
        int bcnt[3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; dcnt[i] = 0; bcnt[i] = 0;
        end
        @(negedge clk);
        drive(1'b1, v.sub, v.a, v.b, v.cin);
        @(posedge clk);
        #1;
        drive(1'b0, ~v.sub, ~v.a, ~v.b, ~v.cin);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 3; i++) begin
                if (busy_a[i]) bcnt[i]++;
                if (done_a[i]) begin
                    dcnt[i]++;
                    if (lat[i] < 0) lat[i] = k;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk({tag, " sum"},     i, 32'(sum_a[i]),  32'(v.sum));
            chk({tag, " cout"},    i, 32'(cout_a[i]), 32'(v.cout));
            chk({tag, " ovf"},     i, 32'(ovf_a[i]),  32'(v.ovf));
            chk({tag, " zero"},    i, 32'(zero_a[i]), 32'(v.zero));
            chk({tag, " latency"}, i, 32'(lat[i]),    32'(nchunk_of(i)));
            chk({tag, " donecnt"}, i, 32'(dcnt[i]),   32'd1);
            chk({tag, " busycnt"}, i, 32'(bcnt[i]),   32'(nchunk_of(i)));
        end
    endtask

    vec_t vecs [11];

    initial begin
        int          d_edge[2];
        logic [15:0] d_sum [2];
        int          nd;
        int          bad_done;
        logic [15:0] ra, rb;
        logic        rs, rc;

        //              sub   a         b         cin   sum       cout  ovf   zero
        vecs[0]  = '{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset busy", i, 32'(busy_a[i]), 32'd0);
            chk("reset done", i, 32'(done_a[i]), 32'd0);
            chk("reset sum",  i, 32'(sum_a[i]),  32'd0);
            chk("reset flags", i, {29'd0, cout_a[i], ovf_a[i], zero_a[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 11; n++) begin
            run_op(vecs[n], $sformatf("vec%0d", n));
        end

        // Start pulse during RUN is ignored (CHUNK=4 instance).
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0010, 16'h0020, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h1111, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h1111, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h1111, 16'h1111, 1'b0);
        @(posedge clk); #1;
        chk("ignore done@3", 1, 32'(done_a[1]), 32'd0);
        @(posedge clk); #1;
        chk("ignore done@4", 1, 32'(done_a[1]), 32'd1);
        chk("ignore sum",    1, 32'(sum_a[1]),  32'h0030);
        repeat (25) @(posedge clk);

        // Start held through DONE: second op accepted with no bubble.
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0100, 16'h0200, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'h0009, 16'h0003, 1'b0);
        nd = 0;
        d_edge[0] = -1; d_edge[1] = -1;
        d_sum[0] = 16'h0000; d_sum[1] = 16'h0000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                chk("b2b busy@5", 1, 32'(busy_a[1]), 32'd1);
                drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            end
            if (done_a[1]) begin
                if (nd < 2) begin
                    d_edge[nd] = k;
                    d_sum[nd]  = sum_a[1];
                end
                nd++;
            end
        end
        chk("b2b donecnt", 1, 32'(nd),        32'd2);
        chk("b2b edge1",   1, 32'(d_edge[0]), 32'd4);
        chk("b2b edge2",   1, 32'(d_edge[1]), 32'd9);
        chk("b2b sum1",    1, 32'(d_sum[0]),  32'h0300);
        chk("b2b sum2",    1, 32'(d_sum[1]),  32'h0006);
        chk("b2b cout2",   1, 32'(cout_a[1]), 32'd1);
        repeat (25) @(posedge clk);

        // Reset after two chunks: outputs clear at once, no done pulse.
        @(negedge clk);
        drive(1'b1, 1'b0, 16'hAAAA, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 1, 32'(busy_a[1]), 32'd0);
        chk("midrst done", 1, 32'(done_a[1]), 32'd0);
        chk("midrst sum",  1, 32'(sum_a[1]),  32'd0);
        chk("midrst cout", 1, 32'(cout_a[1]), 32'd0);
        bad_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_a[1]) bad_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_a[1] || busy_a[1]) bad_done++;
        end
        chk("midrst no done", 1, 32'(bad_done), 32'd0);
        run_op(vecs[6], "post-reset");

        // Random operands against the reference model on all three chunk sizes.
        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            run_op(ref_model(rs, ra, rb, rc), $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor and the sequential successor to the fixed 4-bit ripple-carry adder. It processes a WIDTH-bit operation CHUNK bits per clock, least-significant chunk first, using a registered inter-chunk carry. It adds carry-in, a subtract mode, a start/busy/done handshake and status flags (carry, signed overflow, zero). It sits on datapath units that need wide adds at a reduced combinational depth.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 1.
CHUNK, 4, bits summed per cycle by the ripple chain; 1 <= CHUNK <= WIDTH, and WIDTH % CHUNK == 0. Elaboration fails otherwise.
NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous assert, active-low.
start  input  1  request; sampled only when the block is idle (IDLE or DONE).
sub  input  1  0 = a+b+cin; 1 = a-b-cin.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result is valid.
sum  output  WIDTH  result.
cout  output  1  raw carry out of the MSB (in sub mode, 1 = no borrow).
ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
zero  output  1  high when sum == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. busy, done, sum, cout, ovf and zero are all 0. The internal operand, partial-sum, carry and counter registers are cleared. Reset mid-RUN abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (accepting edge E0):
  - latch a, b' = sub ? ~b : b, and carry = cin ^ sub;
  - set cnt=0 and go to RUN.
  - Start is not accepted in RUN; it is ignored and the operands are not re-latched.
- RUN, each edge Ek (k=1..NCHUNK):
  - the chunk at bits [cnt*CHUNK +: CHUNK] passes through the ripple chain with the registered carry;
  - the partial sum is written to that slice and carry is updated;
  - cnt increments.
- On edge E_NCHUNK:
  - sum takes the full partial sum; cout takes the final carry; ovf takes carry-into-MSB XOR final carry; zero takes (full sum == 0);
  - done=1 and state=DONE.
- DONE: done is high for exactly one cycle. On the next edge, go to IDLE with done=0, or go to RUN if start=1 (back-to-back, zero bubble).
- Latency: done is visible NCHUNK edges after the accepting edge. Throughput is one operation per NCHUNK+1 cycles.
- sum, cout, ovf and zero are registered. They update only on the completion edge and hold until the next completion or reset. Partial results are never visible.
- busy=1 exactly while the state is RUN.
- CHUNK==WIDTH gives NCHUNK=1: one RUN cycle, with done one edge after acceptance.
- Carry propagates across chunk boundaries through the register only. There is no combinational path from inputs to outputs.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only via cout and ovf.

Decomposition:
- Shared package adder_pkg: the state enum (IDLE, RUN, DONE), and a function or check enforcing the WIDTH/CHUNK legality rule.
- One sub-module, full_adder_chain: a combinational CHUNK-bit ripple of full adders. Inputs are x, y and ci; outputs are s, co and c_msb_in (the carry into its top bit, used for ovf on the last chunk).
- The top level holds the FSM, counter, operand/carry registers and output flags.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0x0001, b=0x0001, cin=0, sub=0 -> sum=0x0002, cout=0, ovf=0, zero=0; done exactly 4 edges after acceptance; busy high for 4 cycles.
2. a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0, zero=1 (carry ripples through all 4 chunk registers). Repeat with a=0x7FFF -> sum=0x8000, ovf=1, cout=0.
3. Sub: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0001, cin=1 -> sum=0x0001.
4. Handshake: pulse start with a different a/b during RUN -> ignored, first result returned. Hold start high during the DONE cycle -> the new op is accepted with no bubble; done pulses are 5 cycles apart.
5. Drop rst_n mid-RUN (after 2 chunks) -> all outputs 0 immediately, no done pulse. After release, 0x1234+0x4321 -> sum=0x5555.
6. Parameter sweep: CHUNK=1, 4 and 16 with random operands vs. a reference model -> results identical, latency = NCHUNK edges.
